range_match_counter: RTL and testbench
======================================

# range_match_counter

Single-lane scan engine that consumes the range and value memories described by the package parameters and counts how many values fall inside at least one range. It is the stage directly downstream of the range/value ROMs initialised from the hex files: it drives their read addresses, compares each value against the ranges, and reports the final count to the result/readout logic. Parallel builds instantiate one lane per value bank, each with its own hex slice.

## Interface
- DATA_WIDTH, 49, width of range bounds and values (unsigned)
- RANGES_COUNT, 190, number of ranges in range memory
- VALUES_COUNT, 1000, number of values in value memory
- COUNTER_WIDTH, 10, width of the count output
- RANGE_ADDR_WIDTH, 8, range memory address width
- VALUE_ADDR_WIDTH, 10, value memory address width
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- range_addr  out  RANGE_ADDR_WIDTH  range memory read address
- range_lo  in  DATA_WIDTH  lower bound, valid 1 cycle after range_addr
- range_hi  in  DATA_WIDTH  upper bound, valid 1 cycle after range_addr
- value_addr  out  VALUE_ADDR_WIDTH  value memory read address
- value_data  in  DATA_WIDTH  value, valid 1 cycle after value_addr
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse when count is final
- count  out  COUNTER_WIDTH  number of matched values

## Operation
- Memories are synchronous-read, 1-cycle latency; no handshake on the memory side.
- States: IDLE, LOAD_VAL, LATCH_VAL, SCAN, NEXT, DONE.
- IDLE: start=1 -> clear count, vidx=0, go LOAD_VAL. start=0 -> stay; count holds last result.
- LOAD_VAL: value_addr=vidx. -> LATCH_VAL.
- LATCH_VAL: v_reg<=value_data; range_addr=0; cmp_idx<=0. -> SCAN.
- SCAN (each cycle): compare range_lo/range_hi (data for cmp_idx) with v_reg; issue range_addr=cmp_idx+1 (clamped to RANGES_COUNT-1).
  - hit (range_lo <= v_reg <= range_hi, unsigned, inclusive both ends): count+1, -> NEXT. Remaining ranges are not examined; in-flight read is discarded.
  - miss and cmp_idx==RANGES_COUNT-1: -> NEXT.
  - otherwise cmp_idx+1, stay.
- NEXT: vidx==VALUES_COUNT-1 -> DONE; else vidx+1, -> LOAD_VAL.
- DONE: done=1 for this single cycle, -> IDLE.
- Range with lo>hi matches nothing. A value inside several overlapping ranges counts once.
- count saturates at all-ones; no wrap.
- start while busy or in DONE: ignored.

## Timing
- Reset values: range_addr=0, value_addr=0, busy=0, done=0, count=0, state IDLE.
- Reset asserted mid-scan: immediately IDLE with all outputs at reset values; partial count discarded.
- start sampled at edge N -> busy high from cycle N+1 (first LOAD_VAL).
- Per-value cost: miss = RANGES_COUNT+3 cycles; hit at range index k = k+4 cycles.
- done high in the cycle after the final NEXT; busy low in that cycle. count is stable from the done cycle until the next accepted start.
- Next start is accepted no earlier than the cycle after done (IDLE).
- Comparison is combinational on registered v_reg and memory outputs; count updates at the SCAN edge where the hit is seen.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, toggle start -> count=0, busy=0, done=0, addresses 0; start ignored during reset.
- Basic (RANGES_COUNT=3, VALUES_COUNT=6): ranges [3,5],[10,14],[16,20]; values 1,5,8,11,17,32 -> count=3; done high exactly 33 cycles after busy first rises (costs 6+4+6+5+6+6).
- Boundaries: ranges [7,7],[20,10],[0,2^49-1 disabled in first run]; values 7, 8, 15 -> count=1; rerun with range 3 = [0,2^49-1] and value 2^49-1 added -> every value matches, count equals VALUES_COUNT.
- Overlap and early exit: ranges [1,10],[5,15]; value 6 -> count=1, SCAN lasts 1 cycle (hit at k=0), range_addr never reaches beyond 1.
- Control: start pulsed while busy -> ignored, count/timing identical to single-start run; rst_n pulsed low mid-SCAN -> IDLE, count=0; fresh start -> full correct result.
- Saturation: COUNTER_WIDTH=2, VALUES_COUNT=5, all values in range -> count=3 at done, no wrap.

Source files
------------

// File: rtl/range_match_counter.sv
// Single-lane range match scanner: walks the value memory, compares each value against
// the range memory in order, and counts values that land inside at least one range.
module range_match_counter #(
  parameter int unsigned DATA_WIDTH       = 49,
  parameter int unsigned RANGES_COUNT     = 190,
  parameter int unsigned VALUES_COUNT     = 1000,
  parameter int unsigned COUNTER_WIDTH    = 10,
  parameter int unsigned RANGE_ADDR_WIDTH = 8,
  parameter int unsigned VALUE_ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [RANGE_ADDR_WIDTH-1:0] range_addr,
  input  logic [DATA_WIDTH-1:0]       range_lo,
  input  logic [DATA_WIDTH-1:0]       range_hi,
  output logic [VALUE_ADDR_WIDTH-1:0] value_addr,
  input  logic [DATA_WIDTH-1:0]       value_data,
  output logic                        busy,
  output logic                        done,
  output logic [COUNTER_WIDTH-1:0]    count
);

  localparam logic [RANGE_ADDR_WIDTH-1:0] LAST_RANGE = RANGE_ADDR_WIDTH'(RANGES_COUNT - 1);
  localparam logic [VALUE_ADDR_WIDTH-1:0] LAST_VALUE = VALUE_ADDR_WIDTH'(VALUES_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_VAL,
    S_LATCH_VAL,
    S_SCAN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                      state;
  logic [VALUE_ADDR_WIDTH-1:0] vidx;
  logic [RANGE_ADDR_WIDTH-1:0] cmp_idx;
  logic [DATA_WIDTH-1:0]       v_reg;

  logic                        hit_c;
  logic [RANGE_ADDR_WIDTH-1:0] range_addr_inc_c;
  logic [COUNTER_WIDTH-1:0]    count_inc_c;

  // Range data on the bus always belongs to cmp_idx; range_addr runs one index ahead.
  assign hit_c            = (range_lo <= v_reg) && (v_reg <= range_hi);
  assign range_addr_inc_c = (range_addr == LAST_RANGE) ? LAST_RANGE
                                                       : range_addr + RANGE_ADDR_WIDTH'(1);
  assign count_inc_c      = (&count) ? count : count + COUNTER_WIDTH'(1);

  // Addresses are loaded on the edge entering a state so they are presented during it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vidx       <= '0;
      cmp_idx    <= '0;
      v_reg      <= '0;
      range_addr <= '0;
      value_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count      <= '0;
            vidx       <= '0;
            value_addr <= '0;
            range_addr <= '0;
            busy       <= 1'b1;
            state      <= S_LOAD_VAL;
          end
        end
        S_LOAD_VAL: begin
          range_addr <= '0;
          state      <= S_LATCH_VAL;
        end
        S_LATCH_VAL: begin
          v_reg      <= value_data;
          cmp_idx    <= '0;
          range_addr <= range_addr_inc_c;
          state      <= S_SCAN;
        end
        S_SCAN: begin
          if (hit_c) begin
            count <= count_inc_c;
            state <= S_NEXT;
          end else if (cmp_idx == LAST_RANGE) begin
            state <= S_NEXT;
          end else begin
            cmp_idx    <= cmp_idx + RANGE_ADDR_WIDTH'(1);
            range_addr <= range_addr_inc_c;
          end
        end
        S_NEXT: begin
          if (vidx == LAST_VALUE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            vidx       <= vidx + VALUE_ADDR_WIDTH'(1);
            value_addr <= vidx + VALUE_ADDR_WIDTH'(1);
            state      <= S_LOAD_VAL;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_match_counter.sv
// Bench for range_match_counter: memory models, a first-hit reference model for count,
// per-scan cycle cost and peak range address, plus a small saturating instance.
module tb_range_match_counter;

  localparam int unsigned DW  = 49;
  localparam int unsigned RM  = 8;
  localparam int unsigned VM  = 12;
  localparam int unsigned CW  = 10;
  localparam int unsigned RAW = 8;
  localparam int unsigned VAW = 10;
  localparam int unsigned RS  = 3;
  localparam int unsigned VS  = 5;
  localparam int unsigned CWS = 2;
  localparam int          LIMIT = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           start;
  logic [RAW-1:0] range_addr;
  logic [DW-1:0]  range_lo, range_hi;
  logic [VAW-1:0] value_addr;
  logic [DW-1:0]  value_data;
  logic           busy, done;
  logic [CW-1:0]  count;

  logic           start_s;
  logic [RAW-1:0] range_addr_s;
  logic [DW-1:0]  range_lo_s, range_hi_s;
  logic [VAW-1:0] value_addr_s;
  logic [DW-1:0]  value_data_s;
  logic           busy_s, done_s;
  logic [CWS-1:0] count_s;

  logic [DW-1:0] lo_mem [256];
  logic [DW-1:0] hi_mem [256];
  logic [DW-1:0] val_mem[1024];
  logic [DW-1:0] lo_s   [256];
  logic [DW-1:0] hi_s   [256];
  logic [DW-1:0] val_s  [1024];

  int tests = 0;
  int fails = 0;

  range_match_counter #(
    .DATA_WIDTH(DW), .RANGES_COUNT(RM), .VALUES_COUNT(VM),
    .COUNTER_WIDTH(CW), .RANGE_ADDR_WIDTH(RAW), .VALUE_ADDR_WIDTH(VAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .range_addr(range_addr), .range_lo(range_lo), .range_hi(range_hi),
    .value_addr(value_addr), .value_data(value_data),
    .busy(busy), .done(done), .count(count)
  );

  range_match_counter #(
    .DATA_WIDTH(DW), .RANGES_COUNT(RS), .VALUES_COUNT(VS),
    .COUNTER_WIDTH(CWS), .RANGE_ADDR_WIDTH(RAW), .VALUE_ADDR_WIDTH(VAW)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .range_addr(range_addr_s), .range_lo(range_lo_s), .range_hi(range_hi_s),
    .value_addr(value_addr_s), .value_data(value_data_s),
    .busy(busy_s), .done(done_s), .count(count_s)
  );

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    range_lo     <= lo_mem[range_addr];
    range_hi     <= hi_mem[range_addr];
    value_data   <= val_mem[value_addr];
    range_lo_s   <= lo_s[range_addr_s];
    range_hi_s   <= hi_s[range_addr_s];
    value_data_s <= val_s[value_addr_s];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand49();
    return DW'({$urandom(), $urandom()});
  endfunction

  // First matching range per value decides both the hit and the time spent on it.
  task automatic model(output int exp_cnt, output int exp_cyc, output int exp_max);
    int k;
    int ra;
    exp_cnt = 0; exp_cyc = 0; exp_max = 0;
    for (int v = 0; v < int'(VM); v++) begin
      k = -1;
      for (int r = 0; r < int'(RM); r++)
        if (k < 0 && lo_mem[r] <= val_mem[v] && val_mem[v] <= hi_mem[r]) k = r;
      if (k >= 0) begin
        if (exp_cnt < (2 ** CW) - 1) exp_cnt++;
        exp_cyc += k + 4;
        ra = (k + 1 < int'(RM) - 1) ? k + 1 : int'(RM) - 1;
      end else begin
        exp_cyc += int'(RM) + 3;
        ra = int'(RM) - 1;
      end
      if (ra > exp_max) exp_max = ra;
    end
  endtask

  task automatic disable_ranges();
    for (int r = 0; r < int'(RM); r++) begin
      lo_mem[r] = DW'(1);
      hi_mem[r] = DW'(0);
    end
  endtask

  task automatic fill_random(input int maxv, input int span);
    for (int r = 0; r < int'(RM); r++) begin
      lo_mem[r] = DW'($urandom_range(0, maxv));
      if ($urandom_range(0, 4) == 0) hi_mem[r] = DW'($urandom_range(0, maxv));
      else                           hi_mem[r] = lo_mem[r] + DW'($urandom_range(0, span));
    end
    for (int v = 0; v < int'(VM); v++) val_mem[v] = DW'($urandom_range(0, maxv + span));
  endtask

  task automatic run_scan(input string tag, input bit noisy);
    int ecnt, ecyc, emax, cyc, maxra;
    bit busy_ok;
    model(ecnt, ecyc, emax);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, ":busy_rise"}, 64'(busy), 64'd1);
    cyc = 0; maxra = int'(range_addr); busy_ok = 1'b1;
    while (!done && cyc < LIMIT) begin
      if (!busy) busy_ok = 1'b0;
      if (int'(range_addr) > maxra) maxra = int'(range_addr);
      if (noisy) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, ":cycles"}, 64'(cyc), 64'(ecyc));
    check({tag, ":busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, ":busy_in_done"}, 64'(busy), 64'd0);
    check({tag, ":count"}, 64'(count), 64'(ecnt));
    check({tag, ":max_range_addr"}, 64'(maxra), 64'(emax));
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(done), 64'd0);
    @(negedge clk);
    check({tag, ":count_hold"}, 64'(count), 64'(ecnt));
  endtask

  task automatic run_sat(input string tag, input int exp_cnt);
    int cyc;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ":done_seen"}, 64'(cyc < LIMIT), 64'd1);
    check({tag, ":count"}, 64'(count_s), 64'(exp_cnt));
  endtask

  initial begin
    start = 1'b0; start_s = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lo_mem[i] = '0; hi_mem[i] = '0; lo_s[i] = '0; hi_s[i] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      val_mem[i] = '0; val_s[i] = '0;
    end
    #1 rst_n = 1'b0;

    // Reset with start toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = ~start; start_s = ~start_s;
    end
    @(negedge clk);
    check("rst:count", 64'(count), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:range_addr", 64'(range_addr), 64'd0);
    check("rst:value_addr", 64'(value_addr), 64'd0);
    start = 1'b0; start_s = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst:idle_after", 64'(busy), 64'd0);

    // Basic ranges with misses, hits at several indices.
    disable_ranges();
    lo_mem[0] = DW'(3);  hi_mem[0] = DW'(5);
    lo_mem[1] = DW'(10); hi_mem[1] = DW'(14);
    lo_mem[2] = DW'(16); hi_mem[2] = DW'(20);
    for (int v = 0; v < int'(VM); v++) val_mem[v] = DW'(0);
    val_mem[0] = DW'(1);  val_mem[1] = DW'(5);  val_mem[2] = DW'(8);
    val_mem[3] = DW'(11); val_mem[4] = DW'(17); val_mem[5] = DW'(32);
    run_scan("basic", 1'b0);
    check("basic:count3", 64'(count), 64'd3);

    // Boundaries: single-point range, inverted range, full-span range off then on.
    disable_ranges();
    lo_mem[0] = DW'(7);  hi_mem[0] = DW'(7);
    lo_mem[1] = DW'(20); hi_mem[1] = DW'(10);
    for (int v = 0; v < int'(VM); v++) val_mem[v] = DW'(9);
    val_mem[0] = DW'(7); val_mem[1] = DW'(8); val_mem[2] = DW'(15);
    run_scan("bound", 1'b0);
    check("bound:count1", 64'(count), 64'd1);
    lo_mem[2] = '0; hi_mem[2] = {DW{1'b1}};
    val_mem[3] = {DW{1'b1}};
    run_scan("bound_full", 1'b0);
    check("bound_full:all", 64'(count), 64'(VM));

    // Overlapping ranges: every value hits the first one.
    disable_ranges();
    lo_mem[0] = DW'(1); hi_mem[0] = DW'(10);
    lo_mem[1] = DW'(5); hi_mem[1] = DW'(15);
    for (int v = 0; v < int'(VM); v++) val_mem[v] = DW'(6);
    run_scan("overlap", 1'b0);

    // Start pulses while busy must not disturb the scan.
    fill_random(60, 15);
    run_scan("quiet", 1'b0);
    run_scan("noisy", 1'b1);

    for (int i = 0; i < 4; i++) begin
      fill_random(200, 30);
      run_scan($sformatf("rand%0d", i), 1'b0);
    end

    for (int r = 0; r < int'(RM); r++) begin
      lo_mem[r] = rand49();
      hi_mem[r] = lo_mem[r] + (rand49() >> 2);
    end
    for (int v = 0; v < int'(VM); v++) val_mem[v] = rand49();
    run_scan("wide", 1'b0);

    // Reset in the middle of a scan, then a full clean run.
    fill_random(40, 20);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst:busy", 64'(busy), 64'd0);
    check("midrst:done", 64'(done), 64'd0);
    check("midrst:count", 64'(count), 64'd0);
    check("midrst:range_addr", 64'(range_addr), 64'd0);
    check("midrst:value_addr", 64'(value_addr), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_scan("after_rst", 1'b0);

    // Saturating 2-bit counter.
    lo_s[0] = DW'(0);   hi_s[0] = DW'(100);
    lo_s[1] = DW'(200); hi_s[1] = DW'(300);
    lo_s[2] = DW'(1);   hi_s[2] = DW'(0);
    val_s[0] = DW'(5); val_s[1] = DW'(250); val_s[2] = DW'(500);
    val_s[3] = DW'(600); val_s[4] = DW'(700);
    run_sat("sat_partial", 2);
    val_s[2] = DW'(100); val_s[3] = DW'(0); val_s[4] = DW'(299);
    run_sat("sat_full", 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
